// File: rtl/subtree_rr_scheduler.sv
// Round-robin owner of a single exclusive slot shared by the children of a subtree node.
// One grant at a time, bounded hold time, and priority rotates past the last owner.
module subtree_rr_scheduler #(
   parameter int unsigned NUM_REQ  = 5,
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned ID_W     = $clog2(NUM_REQ),
   parameter int unsigned CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [ID_W-1:0]    grant_id,
   output logic [CNT_W-1:0]   hold_cnt,
   output logic               timeout,
   output logic [ID_W-1:0]    timeout_id
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   localparam logic [ID_W-1:0]  LastIdx   = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(MAX_HOLD - 1);
   localparam bit               TimeoutEn = (MAX_HOLD != 0);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic [ID_W-1:0]    last_ptr_q, last_ptr_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic               timeout_q, timeout_d;
   logic [ID_W-1:0]    timeout_id_q, timeout_id_d;

   logic               hi_found, lo_found;
   logic [ID_W-1:0]    hi_idx, lo_idx, winner;
   logic               owner_req;

   // Lowest set index above last_ptr wins; otherwise wrap to the lowest set index overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (ID_W'(i) > last_ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = ID_W'(i);
            end else begin
               lo_found = 1'b1;
               lo_idx   = ID_W'(i);
            end
         end
      end
      winner = hi_found ? hi_idx : lo_idx;
   end

   // grant is one-hot, so this selects the owner's request bit.
   assign owner_req = |(req & grant_q);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      grant_id_d   = grant_id_q;
      last_ptr_d   = last_ptr_q;
      hold_cnt_d   = hold_cnt_q;
      timeout_d    = 1'b0;
      timeout_id_d = timeout_id_q;
      unique case (state_q)
         StIdle: begin
            if (hi_found || lo_found) begin
               grant_d    = NUM_REQ'(1) << winner;
               grant_id_d = winner;
               last_ptr_d = winner;
               hold_cnt_d = '0;
               state_d    = StGrant;
            end
         end
         StGrant: begin
            if (!owner_req) begin
               grant_d    = '0;
               hold_cnt_d = '0;
               state_d    = StIdle;
            end else if (TimeoutEn && (hold_cnt_q == HoldLast)) begin
               grant_d      = '0;
               hold_cnt_d   = '0;
               timeout_d    = 1'b1;
               timeout_id_d = grant_id_q;
               state_d      = StIdle;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         grant_id_q   <= '0;
         last_ptr_q   <= LastIdx;
         hold_cnt_q   <= '0;
         timeout_q    <= 1'b0;
         timeout_id_q <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         grant_id_q   <= grant_id_d;
         last_ptr_q   <= last_ptr_d;
         hold_cnt_q   <= hold_cnt_d;
         timeout_q    <= timeout_d;
         timeout_id_q <= timeout_id_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_id    = grant_id_q;
   assign hold_cnt    = hold_cnt_q;
   assign timeout     = timeout_q;
   assign timeout_id  = timeout_id_q;

endmodule

// File: tb/tb_subtree_rr_scheduler.sv
// Bench for subtree_rr_scheduler: per-cycle vector tables with expected outputs queued at
// drive time and compared after the following clock edge, plus a mid-session reset sequence.
module tb_subtree_rr_scheduler;

   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [2:0]   grant_id;
   logic [7:0]   hold_cnt;
   logic         timeout;
   logic [2:0]   timeout_id;

   always #5 clk = ~clk;

   subtree_rr_scheduler #(
      .NUM_REQ (5),
      .MAX_HOLD(16),
      .ID_W    (3),
      .CNT_W   (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .grant      (grant),
      .grant_valid(grant_valid),
      .grant_id   (grant_id),
      .hold_cnt   (hold_cnt),
      .timeout    (timeout),
      .timeout_id (timeout_id)
   );

   // gidx = -1 means no grant expected after the edge.
   typedef struct {
      logic [N-1:0] req;
      int           gidx;
      int           hold;
      bit           to;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   exp_id = 0;
   int   exp_toid = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   function automatic void add(input logic [N-1:0] r, input int gi, input int h, input bit t);
      vec_t v;
      v.req  = r;
      v.gidx = gi;
      v.hold = h;
      v.to   = t;
      tbl.push_back(v);
   endfunction

   // Called at a falling edge: drive, queue the expectation, compare after the rising edge.
   task automatic step(input vec_t v, input string tag);
      vec_t         e;
      logic [N-1:0] g;
      req = v.req;
      exp_q.push_back(v);
      @(posedge clk);
      #2;
      e = exp_q.pop_front();
      g = '0;
      if (e.gidx >= 0) g = N'(1) << e.gidx;
      if (e.to) exp_toid = exp_id;
      if (e.gidx >= 0) exp_id = e.gidx;
      chk({tag, " grant"},       32'(grant),       32'(g));
      chk({tag, " grant_valid"}, 32'(grant_valid), 32'(e.gidx >= 0));
      chk({tag, " grant_id"},    32'(grant_id),    32'(exp_id));
      chk({tag, " hold_cnt"},    32'(hold_cnt),    32'(e.hold));
      chk({tag, " timeout"},     32'(timeout),     32'(e.to));
      chk({tag, " timeout_id"},  32'(timeout_id),  32'(exp_toid));
      @(negedge clk);
   endtask

   task automatic run(input string tag);
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("%s[%0d]", tag, i));
      tbl.delete();
   endtask

   task automatic check_idle_reset(input string tag);
      chk({tag, " grant"},       32'(grant),       32'(0));
      chk({tag, " grant_valid"}, 32'(grant_valid), 32'(0));
      chk({tag, " grant_id"},    32'(grant_id),    32'(0));
      chk({tag, " hold_cnt"},    32'(hold_cnt),    32'(0));
      chk({tag, " timeout"},     32'(timeout),     32'(0));
      chk({tag, " timeout_id"},  32'(timeout_id),  32'(0));
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      req = '0;
      #1;
      check_idle_reset(tag);
      @(negedge clk);
      rst = 1'b0;
      exp_id   = 0;
      exp_toid = 0;
   endtask

   initial begin
      logic [N-1:0] m;

      // Single requester, grant then release.
      do_reset("reset0");
      add(5'b00001, 0, 0, 0);
      add(5'b00000, -1, 0, 0);
      run("single");

      // All request; each owner holds 3 cycles then drops: order 0,1,2,3,4,0.
      do_reset("reset1");
      for (int k = 0; k < 6; k++) begin
         m = 5'b11111;
         m[k % N] = 1'b0;
         add(5'b11111, k % N, 0, 0);
         add(5'b11111, k % N, 1, 0);
         add(5'b11111, k % N, 2, 0);
         add(m, -1, 0, 0);
      end
      run("rr");

      // Lone requester never releases: 16 granted cycles, timeout, re-grant.
      do_reset("reset2");
      add(5'b01000, 3, 0, 0);
      for (int h = 1; h < 16; h++) add(5'b01000, 3, h, 0);
      add(5'b01000, -1, 0, 1);
      add(5'b01000, 3, 0, 0);
      add(5'b01000, 3, 1, 0);
      add(5'b00000, -1, 0, 0);
      run("lone_to");

      // Timed-out owner 2 loses to waiting 4; then 4 releases on its 16th cycle.
      do_reset("reset3");
      add(5'b00100, 2, 0, 0);
      for (int h = 1; h < 16; h++) add(5'b10100, 2, h, 0);
      add(5'b10100, -1, 0, 1);
      add(5'b10100, 4, 0, 0);
      run("to_rotate");
      for (int h = 1; h < 16; h++) add(5'b10000, 4, h, 0);
      add(5'b00000, -1, 0, 0);
      add(5'b00000, -1, 0, 0);
      run("rel_at_limit");

      // Reset in the middle of a session.
      do_reset("reset4");
      add(5'b00010, 1, 0, 0);
      add(5'b00010, 1, 1, 0);
      add(5'b00010, 1, 2, 0);
      run("pre_rst");
      #1;
      rst = 1'b1;
      #1;
      check_idle_reset("mid_rst_async");
      @(posedge clk);
      #2;
      chk("mid_rst_edge timeout", 32'(timeout), 32'(0));
      chk("mid_rst_edge grant",   32'(grant),   32'(0));
      @(negedge clk);
      rst = 1'b0;
      exp_id   = 0;
      exp_toid = 0;
      add(5'b10010, 1, 0, 0);
      add(5'b10010, 1, 1, 0);
      add(5'b00000, -1, 0, 0);
      add(5'b10010, 4, 0, 0);
      run("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/subtree_rr_scheduler.md
Name: subtree_rr_scheduler

Overview:
- Round-robin scheduler that shares one exclusive resource slot among the NUM_REQ child instances of a subtree node. The standard subtree fan-out is 5.
- Sits in the parent node, beside the child instances.
- Each child raises a request and holds it while it uses the slot.
- The scheduler grants one child at a time, enforces a maximum hold time, and rotates priority so that no child is starved.

Parameters:
- NUM_REQ, 5, number of requesters (children); legal range 2..16.
- MAX_HOLD, 16, maximum consecutive grant cycles per session; 0 disables the timeout.
- ID_W, $clog2(NUM_REQ), width of the grant index.
- CNT_W, 8, width of the hold counter; must satisfy MAX_HOLD < 2**CNT_W.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-child request level; held high for the whole use of the slot.
- grant  output  NUM_REQ  one-hot grant, registered; all zeros when the slot is free.
- grant_valid  output  1  high when any grant bit is set.
- grant_id  output  ID_W  index of the current owner; holds the last owner while idle.
- hold_cnt  output  CNT_W  cycles elapsed in the current session; 0 when idle.
- timeout  output  1  one-cycle pulse when a session is force-terminated.
- timeout_id  output  ID_W  owner index captured at timeout; holds its value until the next timeout.

Behaviour:
- Reset (asynchronous assertion, synchronous-safe release):
  - grant=0, grant_valid=0, grant_id=0, hold_cnt=0, timeout=0, timeout_id=0.
  - State IDLE; last_ptr=NUM_REQ-1, so index 0 has top priority after reset.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first set bit searching from (last_ptr+1) mod NUM_REQ upward, with wrap-around.
  - On the next edge: register grant/grant_id, set last_ptr to the winner, clear hold_cnt to 0, go to GRANT.
  - Latency from req to grant is 1 cycle.
  - If req==0, stay in IDLE and hold all outputs.
- GRANT:
  - hold_cnt increments by 1 each cycle while req[grant_id]=1.
  - Release: req[grant_id]=0 sampled at an edge → grant=0, hold_cnt=0, go to IDLE.
  - At least one idle cycle always separates two sessions. Back-to-back reuse therefore costs 2 cycles from release to the next grant.
  - Timeout (MAX_HOLD>0): when hold_cnt==MAX_HOLD-1 and req[grant_id] is still 1, the next edge does all of the following:
    - grant=0, hold_cnt=0, go to IDLE;
    - timeout=1 for exactly one cycle, timeout_id=grant_id.
  - After a timeout, the timed-out child has lowest priority at re-arbitration, because last_ptr already points at it.
  - It is re-granted only if no other child requests.
  - Release and timeout on the same edge: treat as a release; no timeout pulse.
- Non-owner requests are ignored during GRANT; they do not preempt and they do not change last_ptr.
- A requester that drops req before it is granted simply loses its turn. No request is latched.
- Requests on indices ≥ NUM_REQ cannot occur (the port width is exact).
- Reset mid-session: grant drops immediately (asynchronously), priority returns to index 0, and no timeout pulse is issued.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_id matches the set grant bit whenever grant_valid=1.
  - hold_cnt never exceeds MAX_HOLD-1.
- MAX_HOLD=0: no timeout; hold_cnt saturates at 2**CNT_W-1.

Test Plan:
- Reset then req=5'b00001 → grant=00001 one cycle later, grant_id=0; drop req → grant=0 the next cycle, grant_valid=0.
- req=5'b11111 held, with each owner releasing after 3 granted cycles → grant order is 0,1,2,3,4,0; each grant lasts 3 cycles with 1 idle cycle between grants.
- Only req[3] high and never released, MAX_HOLD=16 → grant for 16 cycles (hold_cnt 0..15), then timeout=1 with timeout_id=3; grant=0 for 1 cycle, then re-granted to 3.
- req[2] held past the timeout while req[4] is high → after the timeout, the next grant goes to 4, not 2.
- req[1] granted; assert rst in the middle of the session → grant=0 immediately with no timeout pulse; after reset release with req=5'b10010, index 1 is granted first (priority restarts at 0).
- Owner drops req exactly on its 16th cycle, when a timeout would fire → no timeout pulse; treated as a normal release.
